serial_add_ctrl: RTL and testbench



---
 rtl/serial_add_ctrl_pkg.sv | 24 ++
 rtl/fa_bit_cell.sv | 26 ++
 rtl/serial_add_ctrl.sv | 114 +++++++++++
 tb/tb_serial_add_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl_pkg
// Description : Shared constants for the bit-serial adder controller.
//               Holds the state codes and the default operand width.
// Revision    : 1.0  initial release
// ============================================================================
package serial_add_ctrl_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // A new request may only be taken while not mid-operation.
  function automatic logic is_accept_state(input state_t st);
    return (st == ST_IDLE) || (st == ST_DONE);
  endfunction

endpackage : serial_add_ctrl_pkg
`default_nettype wire

// File: rtl/fa_bit_cell.sv
`default_nettype none
// ============================================================================
// Module      : fa_bit_cell
// Description : Purely combinational 1-bit full adder shared by the serial
//               adder controller.
// Revision    : 1.0  initial release
// ============================================================================
module fa_bit_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic co
);

  logic half_sum;

  // Classic two-level full adder: propagate term reused for the carry.
  always_comb begin
    half_sum = a ^ b;
    s        = half_sum ^ cin;
    co       = (a & b) | (cin & half_sum);
  end

endmodule : fa_bit_cell
`default_nettype wire

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_add_ctrl
// Description : Bit-serial adder controller. Adds two WIDTH-bit operands LSB
//               first over WIDTH cycles using a single shared full-adder
//               cell, with a start/busy/done handshake.
// Revision    : 1.0  initial release
// ============================================================================
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_sh_nxt;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic             cell_s;
  logic             cell_co;
  logic             accept;
  logic             last_bit;

  fa_bit_cell u_cell (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .cin (carry),
    .s   (cell_s),
    .co  (cell_co)
  );

  // Request acceptance, final-bit detect and the next shifted sum value.
  always_comb begin
    accept     = start && is_accept_state(state);
    last_bit   = (cnt == LAST_BIT);
    sum_sh_nxt = {cell_s, sum_sh[WIDTH-1:1]};
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; DONE with start goes straight back to RUN.
  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE: state_nxt = start ? ST_RUN : ST_IDLE;
      ST_RUN:  state_nxt = last_bit ? ST_DONE : ST_RUN;
      ST_DONE: state_nxt = start ? ST_RUN : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    busy = (state == ST_RUN);
    done = (state == ST_DONE);
  end

  // Datapath: operand capture, serial shift, carry flop, counter, result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == ST_RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      sum_sh <= sum_sh_nxt;
      carry  <= cell_co;
      if (last_bit) begin
        // Counter holds at its last value; it is reloaded on the next accept.
        sum  <= sum_sh_nxt;
        cout <= cell_co;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule : serial_add_ctrl
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_add_ctrl
// Description : Self-checking bench for serial_add_ctrl: vector table plus
//               hand-written multi-cycle sequences with a result scoreboard.
// Revision    : 1.0  initial release
// ============================================================================
module tb_serial_add_ctrl;
  import serial_add_ctrl_pkg::*;

  localparam int W = DEFAULT_WIDTH;
  localparam int TIMEOUT = 40;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
  } vec_t;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int   n_cmp;
  int   n_fail;
  exp_t sb[$];
  vec_t vecs[6];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until done is seen or the budget expires; returns ticks taken.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!done && cycles < TIMEOUT) begin
      tick();
      cycles++;
    end
    if (!done) check("done_timeout", 64'(cycles), 64'(TIMEOUT + 1));
  endtask

  task automatic pop_and_compare(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      check({name, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      e = sb.pop_front();
      check({name, "_sum"}, 64'(sum), 64'(e.sum));
      check({name, "_cout"}, 64'(cout), 64'(e.cout));
    end
  endtask

  // Full single operation from an idle sample point.
  task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc,
                        input logic [W-1:0] es, input logic ec, input string name);
    int   cyc;
    exp_t e;
    a = va; b = vb; cin = vc; start = 1'b1;
    e.sum = es; e.cout = ec;
    sb.push_back(e);
    tick();
    start = 1'b0;
    check({name, "_busy"}, 64'(busy), 64'd1);
    wait_done(cyc);
    check({name, "_latency"}, 64'(cyc), 64'(W));
    pop_and_compare(name);
    tick();
    check({name, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  initial begin
    int           cyc;
    int           pulses;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic [W:0]   model;
    exp_t         e;

    n_cmp  = 0;
    n_fail = 0;
    start  = 1'b0;
    a      = '0;
    b      = '0;
    cin    = 1'b0;
    rst_n  = 1'b0;

    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

    // Reset state
    repeat (2) tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sum", 64'(sum), 64'd0);
    check("rst_cout", 64'(cout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Vector table
    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_cout,
             $sformatf("vec%0d", i));
    end

    // Random operands against an arithmetic model
    for (int i = 0; i < 4; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      model = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
      run_op(ra, rb, rc, model[W-1:0], model[W], $sformatf("rnd%0d", i));
    end

    // Start re-asserted during RUN is ignored
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    e.sum = 8'h30; e.cout = 1'b0; sb.push_back(e);
    tick();
    start = 1'b0;
    repeat (3) tick();
    a = 8'h01; b = 8'h01; start = 1'b1;
    repeat (2) tick();
    start = 1'b0;
    wait_done(cyc);
    check("ign_latency", 64'(cyc + 5), 64'(W));
    pop_and_compare("ign");
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done) pulses++;
    end
    check("ign_extra_done", 64'(pulses), 64'd0);

    // Back-to-back: start held through DONE
    a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
    e.sum = 8'h30; e.cout = 1'b0; sb.push_back(e);
    tick();
    start = 1'b0;
    wait_done(cyc);
    pop_and_compare("b2b_first");
    a = 8'h03; b = 8'h04; start = 1'b1;
    e.sum = 8'h07; e.cout = 1'b0; sb.push_back(e);
    tick();
    start = 1'b0;
    check("b2b_run_resume", 64'(busy), 64'd1);
    check("b2b_hold_sum", 64'(sum), 64'h30);
    wait_done(cyc);
    check("b2b_latency", 64'(cyc), 64'(W));
    pop_and_compare("b2b_second");

    // Asynchronous reset in the middle of RUN
    tick();
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_sum", 64'(sum), 64'd0);
    check("arst_cout", 64'(cout), 64'd0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (done) pulses++;
    end
    check("arst_no_done", 64'(pulses), 64'd0);
    run_op(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "post_rst");

    // Idle hold: result registers ignore input activity without start
    run_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "hold_setup");
    for (int i = 0; i < 20; i++) begin
      a = W'($urandom);
      b = W'($urandom);
      cin = 1'($urandom);
      tick();
      check($sformatf("hold_sum%0d", i), 64'(sum), 64'h96);
      check($sformatf("hold_cout%0d", i), 64'(cout), 64'd0);
    end
    check("hold_busy", 64'(busy), 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_serial_add_ctrl
`default_nettype wire
